img_stream_loader: RTL

IMG_STREAM_LOADER -- requirements
Module: img_stream_loader

---
 rtl/img_loader_pkg.sv | 10 +
 rtl/img_stream_loader_if.sv | 11 +
 rtl/img_bram_sdp.sv | 20 ++
 rtl/img_stream_loader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/img_loader_pkg.sv
// img_loader_pkg: shared defaults, FSM states and width helper for the image stream loader
package img_loader_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int N_PIX_DEF = 784;
    localparam int N_IMG_DEF = 4;
    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/img_stream_loader_if.sv
// img_stream_loader_if: AXI-Stream pixel channel
interface img_stream_loader_if import img_loader_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] tdata;
    logic tvalid;
    logic tready;
    logic tlast;
    modport master (output tdata, tvalid, tlast, input tready);
    modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/img_bram_sdp.sv
// img_bram_sdp: simple dual-port pixel RAM, one write port and one registered read-first read port
module img_bram_sdp import img_loader_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = N_PIX_DEF * N_IMG_DEF,
    parameter int ADDR_W = clog2_min1(DEPTH)
) (
    input  logic              s_axi_aclk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              re,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge s_axi_aclk) begin
        if (we && 32'(wa) < DEPTH) mem[wa] <= wd;
        if (re) rd <= mem[ra];
    end
endmodule

// File: rtl/img_stream_loader.sv
// img_stream_loader: streams one stored image slot over AXI-Stream through a
// 1-cycle RAM read and a 2-entry skid buffer.
module img_stream_loader import img_loader_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_PIX = N_PIX_DEF,
    parameter int N_IMG = N_IMG_DEF,
    parameter int IMG_W = clog2_min1(N_IMG),
    parameter int ADDR_W = clog2_min1(N_IMG * N_PIX)
) (
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [IMG_W-1:0]  img_sel,
    input  logic              abort,
    img_stream_loader_if.master x,
    output logic              busy,
    output logic              done,
    output logic              sel_err
);
    localparam int CNT_W = clog2_min1(N_PIX);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PIX - 1);

    state_t state_q, state_d;
    logic start_q, armed;
    logic [CNT_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic rd_fin, rd_vld, rd_last;
    logic [DATA_W-1:0] ram_q, o_data, s_data;
    logic o_vld, o_last, s_vld, s_last;
    logic active, kill, start_edge, sel_ok, go, pop, last_hs, o_free, issue;
    logic [1:0] occ;

    assign active = state_q != IDLE;
    assign kill = active & abort;
    assign start_edge = start & ~start_q & armed;
    assign sel_ok = 32'(img_sel) < N_IMG;
    assign go = ~active & start_edge & ~abort & sel_ok;
    assign pop = o_vld & x.tready;
    assign last_hs = pop & o_last;
    assign o_free = ~o_vld | pop;
    // words held or in flight after this cycle's pop; a read is issued only if it will find room
    assign occ = 2'(o_vld) + 2'(s_vld) + 2'(rd_vld) - 2'(pop);
    assign issue = active & ~abort & ~rd_fin & (occ < 2'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = go ? FETCH : IDLE;
            FETCH:   state_d = abort ? IDLE : (issue ? STREAM : FETCH);
            STREAM:  state_d = (abort || last_hs) ? IDLE : STREAM;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) state_q <= IDLE;
        else state_q <= state_d;
    end

    // armed blocks a start held high through reset from counting as an edge
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            start_q <= 1'b0;
            armed <= 1'b0;
            done <= 1'b0;
            sel_err <= 1'b0;
            rd_cnt <= '0;
            rd_addr <= '0;
            rd_fin <= 1'b0;
            rd_vld <= 1'b0;
            rd_last <= 1'b0;
        end else begin
            start_q <= start;
            armed <= armed | ~start;
            done <= (state_q == STREAM) & last_hs & ~abort;
            sel_err <= ~active & start_edge & ~abort & ~sel_ok;
            rd_vld <= issue;
            rd_last <= issue & (rd_cnt == LAST_CNT);
            if (go) begin
                rd_cnt <= '0;
                rd_addr <= ADDR_W'(32'(img_sel) * N_PIX);
                rd_fin <= 1'b0;
            end else if (issue) begin
                rd_fin <= rd_cnt == LAST_CNT;
                if (rd_cnt != LAST_CNT) begin
                    rd_cnt <= rd_cnt + 1'b1;
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            o_vld <= 1'b0;
            o_last <= 1'b0;
            o_data <= '0;
            s_vld <= 1'b0;
            s_last <= 1'b0;
            s_data <= '0;
        end else if (kill) begin
            o_vld <= 1'b0;
            o_last <= 1'b0;
            s_vld <= 1'b0;
            s_last <= 1'b0;
        end else if (o_free) begin
            o_vld <= s_vld | rd_vld;
            o_data <= s_vld ? s_data : ram_q;
            o_last <= s_vld ? s_last : rd_last;
            s_vld <= s_vld & rd_vld;
            s_data <= ram_q;
            s_last <= rd_last;
        end else if (rd_vld) begin
            s_vld <= 1'b1;
            s_data <= ram_q;
            s_last <= rd_last;
        end
    end

    img_bram_sdp #(.DATA_W(DATA_W), .DEPTH(N_IMG * N_PIX), .ADDR_W(ADDR_W)) u_ram (
        .s_axi_aclk(s_axi_aclk),
        .we(wr_en),
        .wa(wr_addr),
        .wd(wr_data),
        .re(issue),
        .ra(rd_addr),
        .rd(ram_q)
    );

    assign x.tdata = o_data;
    assign x.tvalid = o_vld;
    assign x.tlast = o_last;
    assign busy = active;
endmodule
